lbp_host: RTL and testbench

LBP_HOST -- requirements
Module: lbp_host

---
 rtl/lbp_host.sv | 141 ++++++++++++++
 tb/tb_lbp_host.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_host.sv
// LBP host: loads a 128x128 gray image, serves pixel reads and LBP result
// writes to a client, then streams the full result image to a sink.
// Ports:
//   clk, reset (async, active-low)
//   ld_valid/ld_data/ld_ready          : raster-order pixel load
//   gray_req/gray_addr/gray_ready/
//   gray_data                          : client pixel reads
//   lbp_valid/lbp_addr/lbp_data/finish : client result writes, completion
//   rd_ready/rd_valid/rd_addr/rd_data  : result stream to sink
//   wr_cnt, addr_err, done             : status
module lbp_host #(
    parameter int IMG_W  = 128,
    parameter int EXP_WR = 15876
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    input  logic        gray_req,
    input  logic [13:0] gray_addr,
    output logic        gray_ready,
    output logic [7:0]  gray_data,
    input  logic        lbp_valid,
    input  logic [13:0] lbp_addr,
    input  logic [7:0]  lbp_data,
    input  logic        finish,
    input  logic        rd_ready,
    output logic        rd_valid,
    output logic [13:0] rd_addr,
    output logic [7:0]  rd_data,
    output logic [13:0] wr_cnt,
    output logic        addr_err,
    output logic        done
);

    localparam int          CB     = $clog2(IMG_W);
    localparam logic [13:0] LAST_A = 14'h3fff;
    localparam logic [13:0] EDGE   = 14'(IMG_W - 1);
    localparam logic [13:0] EXP    = 14'(EXP_WR);

    typedef enum logic [1:0] {LOAD, SERVE, READ, END} state_t;

    state_t      state, state_nx;
    logic [13:0] ld_cnt;
    logic [7:0]  gray_q;
    logic [7:0]  gray_mem [0:16383];
    logic [7:0]  res_mem  [0:16383];

    logic        ld_we, lbp_ok, lbp_bad, xfer, fin_go;
    logic [13:0] wr_cnt_nx, rd_nx_addr;
    logic [7:0]  rd_nx_data;

    // Row/column split relies on IMG_W being a power of two.
    function automatic logic is_border(input logic [13:0] a);
        logic [13:0] row;
        logic [13:0] col;
        row = a >> CB;
        col = a & EDGE;
        return (row == 14'd0) || (row == EDGE) ||
               (col == 14'd0) || (col == EDGE);
    endfunction

    assign ld_we   = (state == LOAD) && ld_valid;
    assign lbp_ok  = (state == SERVE) && lbp_valid && !is_border(lbp_addr);
    assign lbp_bad = ((state == SERVE) && lbp_valid && is_border(lbp_addr)) ||
                     ((state == LOAD) && (lbp_valid || finish));
    assign fin_go  = (state == SERVE) && finish;
    assign xfer    = rd_valid && rd_ready;

    assign wr_cnt_nx  = (lbp_ok && wr_cnt != LAST_A) ? wr_cnt + 14'd1 : wr_cnt;
    assign rd_nx_addr = rd_addr + 14'd1;
    assign rd_nx_data = is_border(rd_nx_addr) ? 8'd0 : res_mem[rd_nx_addr];

    assign ld_ready   = (state == LOAD);
    assign gray_ready = (state == SERVE);
    assign gray_data  = ((state == SERVE) && gray_req) ? gray_mem[gray_addr]
                                                       : gray_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LOAD;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:  if (ld_we && ld_cnt == LAST_A) state_nx = SERVE;
            SERVE: if (finish) state_nx = READ;
            READ:  if (xfer && rd_addr == LAST_A) state_nx = END;
            END:   state_nx = END;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_cnt   <= '0;
            gray_q   <= '0;
            rd_valid <= 1'b0;
            rd_addr  <= '0;
            rd_data  <= '0;
            wr_cnt   <= '0;
            addr_err <= 1'b0;
            done     <= 1'b0;
        end else begin
            done   <= 1'b0;
            wr_cnt <= wr_cnt_nx;
            if (ld_we)
                ld_cnt <= ld_cnt + 14'd1;
            if ((state == SERVE) && gray_req)
                gray_q <= gray_mem[gray_addr];
            // Count check uses the post-write value so a write that
            // coincides with finish is included.
            if (lbp_bad || (fin_go && wr_cnt_nx != EXP))
                addr_err <= 1'b1;
            if (fin_go) begin
                // Address 0 is a corner, so its byte is always zero.
                rd_valid <= 1'b1;
                rd_addr  <= '0;
                rd_data  <= '0;
            end else if (xfer) begin
                if (rd_addr == LAST_A) begin
                    rd_valid <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    rd_addr <= rd_nx_addr;
                    rd_data <= rd_nx_data;
                end
            end
        end
    end

    // Memories are never cleared; writes are blocked while in reset.
    always_ff @(posedge clk) begin
        if (ld_we && reset)
            gray_mem[ld_cnt] <= ld_data;
        if (lbp_ok && reset)
            res_mem[lbp_addr] <= lbp_data;
    end

endmodule

// File: tb/tb_lbp_host.sv
// Self-checking bench for lbp_host: load, serve, full readout,
// stalled readout, error paths and reset mid-READ.
module tb_lbp_host;

    localparam int N = 16384;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        ld_ready;
    logic        gray_req = 1'b0;
    logic [13:0] gray_addr = '0;
    logic        gray_ready;
    logic [7:0]  gray_data;
    logic        lbp_valid = 1'b0;
    logic [13:0] lbp_addr = '0;
    logic [7:0]  lbp_data = '0;
    logic        finish = 1'b0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [13:0] rd_addr;
    logic [7:0]  rd_data;
    logic [13:0] wr_cnt;
    logic        addr_err;
    logic        done;

    lbp_host #(.IMG_W(128), .EXP_WR(15876)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .gray_req(gray_req), .gray_addr(gray_addr),
        .gray_ready(gray_ready), .gray_data(gray_data),
        .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
        .finish(finish), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_cnt(wr_cnt),
        .addr_err(addr_err), .done(done)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] model [N];
    int         dn;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit border(input int a);
        int r = a / 128;
        int c = a % 128;
        return r == 0 || r == 127 || c == 0 || c == 127;
    endfunction

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 5) ^ (a >> 7));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ld_valid = 0; lbp_valid = 0; finish = 0;
        gray_req = 0; rd_ready = 0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic load_img();
        for (int a = 0; a < N; a++) begin
            ld_valid = 1'b1;
            ld_data = 8'(a);
            if (a == N - 1) check("gray_ready_pre", gray_ready, 0);
            tick();
        end
        ld_valid = 1'b0;
        check("gray_ready_post", gray_ready, 1);
    endtask

    task automatic lbp_wr(input int a, input logic [7:0] d, input bit fin);
        lbp_valid = 1'b1;
        lbp_addr = 14'(a);
        lbp_data = d;
        finish = fin;
        tick();
        lbp_valid = 1'b0;
        finish = 1'b0;
        if (!border(a)) model[a] = d;
    endtask

    task automatic read_out(input int stop, input bit stall, output int dcnt);
        int xfer = 0;
        int cyc = 0;
        int bad_a = 0;
        int bad_d = 0;
        int bad_h = 0;
        bit hold;
        logic [13:0] ha;
        logic [7:0] hd;
        dcnt = 0;
        rd_ready = 1'b0;
        for (int i = 0; i < 2 && !rd_valid; i++) tick();
        check("rd_valid_rise", rd_valid, 1);
        while (xfer < stop && cyc < 4 * N) begin
            rd_ready = stall ? ($urandom_range(0, 7) != 0) : 1'b1;
            hold = rd_valid && !rd_ready;
            ha = rd_addr;
            hd = rd_data;
            if (rd_valid && rd_ready) begin
                if (rd_addr != 14'(xfer)) bad_a++;
                if (rd_data != model[xfer]) bad_d++;
                xfer++;
            end
            tick();
            cyc++;
            if (hold && (!rd_valid || rd_addr != ha || rd_data != hd))
                bad_h++;
            if (done) dcnt++;
        end
        rd_ready = 1'b0;
        check("rd_xfers", xfer, stop);
        check("rd_addr_seq", bad_a, 0);
        check("rd_data", bad_d, 0);
        check("rd_stall_hold", bad_h, 0);
    endtask

    initial begin
        for (int a = 0; a < N; a++) model[a] = 8'd0;

        // Reset values and LOAD-state protocol error
        do_reset();
        check("rst_ld_ready", ld_ready, 1);
        check("rst_gray_ready", gray_ready, 0);
        check("rst_gray_data", gray_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_cnt", wr_cnt, 0);
        check("rst_addr_err", addr_err, 0);
        check("rst_done", done, 0);
        lbp_valid = 1'b1;
        lbp_addr = 14'd129;
        tick();
        lbp_valid = 1'b0;
        check("load_lbp_err", addr_err, 1);
        check("load_lbp_wr_cnt", wr_cnt, 0);
        do_reset();
        check("rerst_addr_err", addr_err, 0);

        // Run 1: full client, unstalled readout
        load_img();
        gray_req = 1'b1;
        gray_addr = 14'd300;
        #1 check("gray_300", gray_data, 44);
        tick();
        gray_req = 1'b0;
        gray_addr = 14'd301;
        #1 check("gray_hold", gray_data, 44);
        gray_req = 1'b1;
        gray_addr = 14'd16383;
        #1 check("gray_16383", gray_data, 255);
        gray_req = 1'b0;
        ld_valid = 1'b1;
        ld_data = 8'hff;
        tick();
        ld_valid = 1'b0;
        gray_req = 1'b1;
        gray_addr = 14'd0;
        #1 check("serve_ld_ignored", gray_data, 0);
        gray_req = 1'b0;

        lbp_wr(129, 8'ha5, 1'b0);
        check("wr129_cnt", wr_cnt, 1);
        check("wr129_err", addr_err, 0);
        for (int a = 0; a < N; a++)
            if (!border(a) && a != 129) lbp_wr(a, pat(a), 1'b0);
        check("full_wr_cnt", wr_cnt, 15876);
        check("full_err_pre", addr_err, 0);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("read_gray_ready", gray_ready, 0);
        check("full_err_read", addr_err, 0);
        read_out(N, 1'b0, dn);
        repeat (3) begin
            tick();
            if (done) dn++;
        end
        check("full_done_once", dn, 1);
        check("end_rd_valid", rd_valid, 0);
        check("end_wr_cnt", wr_cnt, 15876);
        check("end_addr_err", addr_err, 0);

        // Run 2: short client, coincident finish, stalled readout, reset
        do_reset();
        check("r2_ld_ready", ld_ready, 1);
        check("r2_wr_cnt", wr_cnt, 0);
        load_img();
        lbp_wr(129, 8'ha5, 1'b0);
        for (int a = 130; a < 138; a++) lbp_wr(a, ~pat(a), 1'b0);
        check("r2_cnt9", wr_cnt, 9);
        check("r2_err9", addr_err, 0);
        lbp_wr(138, 8'h3c, 1'b1);
        check("r2_cnt10", wr_cnt, 10);
        check("r2_short_err", addr_err, 1);
        read_out(5000, 1'b1, dn);
        check("r2_no_done", dn, 0);
        check("r2_rd_addr", rd_addr, 5000);
        check("r2_rd_valid", rd_valid, 1);
        reset = 1'b0;
        #1;
        check("arst_rd_valid", rd_valid, 0);
        check("arst_rd_addr", rd_addr, 0);
        check("arst_rd_data", rd_data, 0);
        check("arst_wr_cnt", wr_cnt, 0);
        check("arst_addr_err", addr_err, 0);
        check("arst_ld_ready", ld_ready, 1);
        check("arst_gray_ready", gray_ready, 0);
        check("arst_gray_data", gray_data, 0);
        check("arst_done", done, 0);
        tick();
        reset = 1'b1;
        tick();

        // Run 3: border writes are rejected
        load_img();
        lbp_wr(128, 8'h11, 1'b0);
        check("brd128_err", addr_err, 1);
        check("brd128_cnt", wr_cnt, 0);
        lbp_wr(255, 8'h22, 1'b0);
        check("brd255_cnt", wr_cnt, 0);
        lbp_wr(300, 8'h33, 1'b0);
        check("int300_cnt", wr_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
